// File: rtl/controller_bus_engine_mux.sv
// Round-robin PHY-ownership arbiter: one bus engine at a time drives SCL/SDA/OD-PP.
// Optional owned-cycle watchdog enabled by defining CTRL_MUX_WATCHDOG_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus parked, no owner, waiting for an enabled request
// WAIT_FREE | bus parked, waiting for the bus-free interval to elapse
// OWNED     | owner's SCL/SDA/OD-PP passed straight through to the PHY
// RELEASE   | one parked cycle, pointer advanced, free counter cleared
module controller_bus_engine_mux #(
    parameter int NumEngines = 2,
    parameter int TimerWidth = 20,
    localparam int IdxWidth = $clog2(NumEngines)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mux_en_i,
    input  logic                  bus_scl_i,
    input  logic                  bus_sda_i,
    input  logic [TimerWidth-1:0] t_bus_free_i,
    input  logic [NumEngines-1:0] eng_req_i,
    output logic [NumEngines-1:0] eng_gnt_o,
    input  logic [NumEngines-1:0] eng_scl_i,
    input  logic [NumEngines-1:0] eng_sda_i,
    input  logic [NumEngines-1:0] eng_sel_od_pp_i,
    output logic                  phy_scl_o,
    output logic                  phy_sda_o,
    output logic                  phy_sel_od_pp_o,
    output logic [IdxWidth-1:0]   owner_o,
    output logic                  bus_busy_o,
    input  logic [TimerWidth-1:0] watchdog_limit_i,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        OWNED     = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TimerWidth-1:0] free_cnt_q;
    logic [IdxWidth-1:0]   owner_q;
    logic [IdxWidth-1:0]   ptr_q;
    logic [IdxWidth-1:0]   ptr_next;
    logic [IdxWidth-1:0]   sel_idx;
    logic                  sel_found;
    logic                  bus_free;
    logic [NumEngines-1:0] req_eff;
    logic                  wd_fire;

`ifdef CTRL_MUX_WATCHDOG_EN
    logic [TimerWidth-1:0] own_cnt_q;
    logic                  timeout_q;
    logic [NumEngines-1:0] blocked_q;
    logic [NumEngines-1:0] blocked_d;

    assign wd_fire = (state_q == OWNED) && (watchdog_limit_i != '0)
                     && ((own_cnt_q + 1'b1) == watchdog_limit_i);
    // A timed-out engine stays locked out until it drops its request once.
    assign req_eff   = eng_req_i & ~blocked_q;
    assign timeout_o = timeout_q;

    always_comb begin
        blocked_d = blocked_q & eng_req_i;
        if (wd_fire) begin
            blocked_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_cnt_q <= '0;
            timeout_q <= 1'b0;
            blocked_q <= '0;
        end else begin
            own_cnt_q <= (state_q == OWNED) ? own_cnt_q + 1'b1 : '0;
            timeout_q <= wd_fire;
            blocked_q <= blocked_d;
        end
    end
`else
    logic unused_watchdog;

    assign unused_watchdog = ^watchdog_limit_i;
    assign wd_fire         = 1'b0;
    assign req_eff         = eng_req_i;
    assign timeout_o       = 1'b0;
`endif

    assign bus_free = (free_cnt_q >= t_bus_free_i);
    assign ptr_next = (owner_q == IdxWidth'(NumEngines - 1)) ? '0 : owner_q + 1'b1;

    // First eligible requester at or after the pointer, wrapping around.
    always_comb begin
        int cand;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NumEngines; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumEngines) begin
                cand = cand - NumEngines;
            end
            if (!sel_found && req_eff[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IdxWidth'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mux_en_i && (|req_eff)) begin
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!mux_en_i || !(|req_eff)) begin
                    state_d = IDLE;
                end else if (bus_free && sel_found) begin
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!eng_req_i[owner_q] || wd_fire) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            free_cnt_q <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == RELEASE) || !(bus_scl_i && bus_sda_i)) begin
                free_cnt_q <= '0;
            end else if (!(&free_cnt_q)) begin
                free_cnt_q <= free_cnt_q + 1'b1;
            end
            if ((state_q == WAIT_FREE) && (state_d == OWNED)) begin
                owner_q <= sel_idx;
            end
            if (state_q == RELEASE) begin
                ptr_q <= ptr_next;
            end
        end
    end

    // Pass-through is combinational from the registered owner/state, so
    // drive changes reach the PHY with zero latency while owned.
    always_comb begin
        eng_gnt_o       = '0;
        phy_scl_o       = 1'b1;
        phy_sda_o       = 1'b1;
        phy_sel_od_pp_o = 1'b0;
        if (state_q == OWNED) begin
            eng_gnt_o[owner_q] = 1'b1;
            phy_scl_o          = eng_scl_i[owner_q];
            phy_sda_o          = eng_sda_i[owner_q];
            phy_sel_od_pp_o    = eng_sel_od_pp_i[owner_q];
        end
    end

    assign owner_o    = owner_q;
    assign bus_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_controller_bus_engine_mux.sv
// Directed bench for controller_bus_engine_mux; watchdog steps run when
// CTRL_MUX_WATCHDOG_EN is defined.
module tb_controller_bus_engine_mux;

    localparam int NumEngines = 2;
    localparam int TimerWidth = 20;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  mux_en_i;
    logic                  bus_scl_i;
    logic                  bus_sda_i;
    logic [TimerWidth-1:0] t_bus_free_i;
    logic [NumEngines-1:0] eng_req_i;
    logic [NumEngines-1:0] eng_gnt_o;
    logic [NumEngines-1:0] eng_scl_i;
    logic [NumEngines-1:0] eng_sda_i;
    logic [NumEngines-1:0] eng_sel_od_pp_i;
    logic                  phy_scl_o;
    logic                  phy_sda_o;
    logic                  phy_sel_od_pp_o;
    logic                  owner_o;
    logic                  bus_busy_o;
    logic [TimerWidth-1:0] watchdog_limit_i;
    logic                  timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    controller_bus_engine_mux #(
        .NumEngines(NumEngines),
        .TimerWidth(TimerWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .mux_en_i        (mux_en_i),
        .bus_scl_i       (bus_scl_i),
        .bus_sda_i       (bus_sda_i),
        .t_bus_free_i    (t_bus_free_i),
        .eng_req_i       (eng_req_i),
        .eng_gnt_o       (eng_gnt_o),
        .eng_scl_i       (eng_scl_i),
        .eng_sda_i       (eng_sda_i),
        .eng_sel_od_pp_i (eng_sel_od_pp_i),
        .phy_scl_o       (phy_scl_o),
        .phy_sda_o       (phy_sda_o),
        .phy_sel_od_pp_o (phy_sel_od_pp_o),
        .owner_o         (owner_o),
        .bus_busy_o      (bus_busy_o),
        .watchdog_limit_i(watchdog_limit_i),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_parked(input string tag);
        check({tag, "_scl"}, 32'(phy_scl_o), 32'd1);
        check({tag, "_sda"}, 32'(phy_sda_o), 32'd1);
        check({tag, "_odpp"}, 32'(phy_sel_od_pp_o), 32'd0);
    endtask

    // Holds reset over one edge with the free counter pinned at 0; returns
    // at posedge+1 with reset released and no edge yet seen.
    task automatic do_reset();
        rst_i            = 1'b1;
        mux_en_i         = 1'b1;
        bus_scl_i        = 1'b1;
        bus_sda_i        = 1'b1;
        eng_req_i        = '0;
        watchdog_limit_i = '0;
        tick(1);
        rst_i = 1'b0;
    endtask

    initial begin
        t_bus_free_i    = 20'd5;
        eng_scl_i       = 2'b11;
        eng_sda_i       = 2'b11;
        eng_sel_od_pp_i = 2'b00;

        // Reset values
        do_reset();
        check("rst_gnt", 32'(eng_gnt_o), 32'd0);
        check_parked("rst");
        check("rst_owner", 32'(owner_o), 32'd0);
        check("rst_busy", 32'(bus_busy_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);

        // Single request from engine 1 with a 5-cycle free interval
        eng_scl_i       = 2'b01;
        eng_sda_i       = 2'b10;
        eng_sel_od_pp_i = 2'b10;
        t_bus_free_i    = 20'd5;
        eng_req_i       = 2'b10;
        tick(1);
        check("wf_busy", 32'(bus_busy_o), 32'd1);
        check("wf_gnt", 32'(eng_gnt_o), 32'd0);
        check_parked("wf");
        tick(4);
        check("pre_grant5", 32'(eng_gnt_o), 32'd0);
        tick(1);
        check("grant6", 32'(eng_gnt_o), 32'b10);
        check("owner1", 32'(owner_o), 32'd1);
        check("e1_scl", 32'(phy_scl_o), 32'd0);
        check("e1_sda", 32'(phy_sda_o), 32'd1);
        check("e1_odpp", 32'(phy_sel_od_pp_o), 32'd1);
        eng_scl_i = 2'b10;
        eng_sda_i = 2'b01;
        #1;
        check("e1_scl_live", 32'(phy_scl_o), 32'd1);
        check("e1_sda_live", 32'(phy_sda_o), 32'd0);
        eng_req_i = 2'b00;
        tick(1);
        check("rel_gnt", 32'(eng_gnt_o), 32'd0);
        check("rel_busy", 32'(bus_busy_o), 32'd1);
        check_parked("rel");
        tick(1);
        check("idle_busy", 32'(bus_busy_o), 32'd0);
        check("idle_owner_kept", 32'(owner_o), 32'd1);

        // Round-robin with both engines requesting, immediate bus-free
        do_reset();
        t_bus_free_i    = 20'd0;
        eng_scl_i       = 2'b10;
        eng_sda_i       = 2'b01;
        eng_sel_od_pp_i = 2'b11;
        eng_req_i       = 2'b11;
        tick(2);
        check("rr_gnt0", 32'(eng_gnt_o), 32'b01);
        check("rr_owner0", 32'(owner_o), 32'd0);
        check("rr_e0_scl", 32'(phy_scl_o), 32'd0);
        check("rr_e0_sda", 32'(phy_sda_o), 32'd1);
        check("rr_e0_odpp", 32'(phy_sel_od_pp_o), 32'd1);
        eng_req_i = 2'b10;
        tick(1);
        check("rr_rel0_gnt", 32'(eng_gnt_o), 32'd0);
        check_parked("rr_rel0");
        eng_req_i = 2'b11;
        tick(1);
        check("rr_idle_busy", 32'(bus_busy_o), 32'd0);
        tick(2);
        check("rr_gnt1", 32'(eng_gnt_o), 32'b10);
        check("rr_owner1", 32'(owner_o), 32'd1);
        check("rr_e1_scl", 32'(phy_scl_o), 32'd1);
        check("rr_e1_sda", 32'(phy_sda_o), 32'd0);
        eng_req_i = 2'b01;
        tick(1);
        check("rr_rel1_gnt", 32'(eng_gnt_o), 32'd0);
        check_parked("rr_rel1");
        eng_req_i = 2'b11;
        tick(3);
        check("rr_gnt0_again", 32'(eng_gnt_o), 32'b01);
        check("rr_owner0_again", 32'(owner_o), 32'd0);

        // SDA glitch at free count 3 restarts the interval
        do_reset();
        t_bus_free_i    = 20'd5;
        eng_scl_i       = 2'b11;
        eng_sda_i       = 2'b11;
        eng_sel_od_pp_i = 2'b00;
        eng_req_i       = 2'b01;
        tick(3);
        bus_sda_i = 1'b0;
        tick(1);
        check("glitch_gnt", 32'(eng_gnt_o), 32'd0);
        bus_sda_i = 1'b1;
        tick(5);
        check("glitch_pre_gnt", 32'(eng_gnt_o), 32'd0);
        tick(1);
        check("glitch_gnt_late", 32'(eng_gnt_o), 32'b01);

        // Asynchronous reset while engine 0 drives push-pull low
        eng_sda_i       = 2'b10;
        eng_sel_od_pp_i = 2'b01;
        #1;
        check("own_sda_low", 32'(phy_sda_o), 32'd0);
        check("own_odpp", 32'(phy_sel_od_pp_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_sda", 32'(phy_sda_o), 32'd1);
        check("arst_odpp", 32'(phy_sel_od_pp_o), 32'd0);
        check("arst_gnt", 32'(eng_gnt_o), 32'd0);
        check("arst_busy", 32'(bus_busy_o), 32'd0);

        // Disabling the mux keeps the owner but blocks new grants
        do_reset();
        t_bus_free_i = 20'd0;
        eng_req_i    = 2'b10;
        tick(2);
        check("en_gnt1", 32'(eng_gnt_o), 32'b10);
        mux_en_i  = 1'b0;
        eng_req_i = 2'b11;
        tick(3);
        check("en_keep_gnt", 32'(eng_gnt_o), 32'b10);
        check("en_keep_owner", 32'(owner_o), 32'd1);
        eng_req_i = 2'b01;
        tick(1);
        check("en_rel_gnt", 32'(eng_gnt_o), 32'd0);
        tick(3);
        check("en_idle_gnt", 32'(eng_gnt_o), 32'd0);
        check("en_idle_busy", 32'(bus_busy_o), 32'd0);

`ifdef CTRL_MUX_WATCHDOG_EN
        // Watchdog forces release after 10 owned cycles
        do_reset();
        t_bus_free_i     = 20'd0;
        watchdog_limit_i = 20'd10;
        eng_req_i        = 2'b11;
        tick(2);
        check("wd_gnt0", 32'(eng_gnt_o), 32'b01);
        tick(9);
        check("wd_cycle10_gnt", 32'(eng_gnt_o), 32'b01);
        check("wd_cycle10_to", 32'(timeout_o), 32'd0);
        tick(1);
        check("wd_rel_gnt", 32'(eng_gnt_o), 32'd0);
        check("wd_timeout", 32'(timeout_o), 32'd1);
        tick(1);
        check("wd_timeout_pulse", 32'(timeout_o), 32'd0);
        tick(2);
        check("wd_gnt1", 32'(eng_gnt_o), 32'b10);
        check("wd_owner1", 32'(owner_o), 32'd1);
`else
        // Without the watchdog a held request keeps ownership indefinitely
        do_reset();
        t_bus_free_i     = 20'd0;
        watchdog_limit_i = 20'd10;
        eng_req_i        = 2'b11;
        tick(14);
        check("nowd_gnt_held", 32'(eng_gnt_o), 32'b01);
        check("nowd_timeout", 32'(timeout_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
